// File: rtl/traffic_light_intersection.sv
// Two-way intersection controller with a pedestrian walk phase inserted after the EW cycle
// whenever a request is pending. All outputs are registered decodes of the phase register.
module traffic_light_intersection #(
  parameter int unsigned GREEN_CYCLES  = 4,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned ALLRED_CYCLES = 1,
  parameter int unsigned WALK_CYCLES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [7:0] seg
);

  typedef enum logic [2:0] {
    PhNsGreen,
    PhNsYellow,
    PhAllRedA,
    PhEwGreen,
    PhEwYellow,
    PhAllRedB,
    PhWalk
  } phase_e;

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  localparam logic [7:0] SegGreen  = 8'b01110111;
  localparam logic [7:0] SegYellow = 8'b01110110;
  localparam logic [7:0] SegRed    = 8'b00001110;
  localparam logic [7:0] SegWalk   = 8'b00111110;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_wait_q, ped_wait_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             walk_q, walk_d;
  logic [7:0]       seg_q, seg_d;

  function automatic logic [CNT_W-1:0] load_val(input phase_e p);
    unique case (p)
      PhNsGreen, PhEwGreen:   load_val = CNT_W'(GREEN_CYCLES - 1);
      PhNsYellow, PhEwYellow: load_val = CNT_W'(YELLOW_CYCLES - 1);
      PhAllRedA, PhAllRedB:   load_val = CNT_W'(ALLRED_CYCLES - 1);
      PhWalk:                 load_val = CNT_W'(WALK_CYCLES - 1);
      default:                load_val = CNT_W'(GREEN_CYCLES - 1);
    endcase
  endfunction

  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    ped_wait_d = ped_wait_q;

    // Requests latch regardless of enable, but never while walk is already being served.
    if (phase_q != PhWalk && ped_req) ped_wait_d = 1'b1;

    if (enable) begin
      if (cnt_q == '0) begin
        unique case (phase_q)
          PhNsGreen:  phase_d = PhNsYellow;
          PhNsYellow: phase_d = PhAllRedA;
          PhAllRedA:  phase_d = PhEwGreen;
          PhEwGreen:  phase_d = PhEwYellow;
          PhEwYellow: phase_d = PhAllRedB;
          PhAllRedB:  phase_d = ped_wait_q ? PhWalk : PhNsGreen;
          PhWalk:     phase_d = PhNsGreen;
          default:    phase_d = PhNsGreen;
        endcase
        cnt_d = load_val(phase_d);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // Entering walk services every request seen so far, including one on this very cycle.
    if (phase_q != PhWalk && phase_d == PhWalk) ped_wait_d = 1'b0;
  end

  always_comb begin
    ns_d   = LampRed;
    ew_d   = LampRed;
    walk_d = 1'b0;
    seg_d  = SegRed;
    unique case (phase_d)
      PhNsGreen: begin
        ns_d  = LampGreen;
        seg_d = SegGreen;
      end
      PhNsYellow: begin
        ns_d  = LampYellow;
        seg_d = SegYellow;
      end
      PhEwGreen:  ew_d = LampGreen;
      PhEwYellow: ew_d = LampYellow;
      PhWalk: begin
        walk_d = 1'b1;
        seg_d  = SegWalk;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= PhNsGreen;
      cnt_q      <= CNT_W'(GREEN_CYCLES - 1);
      ped_wait_q <= 1'b0;
      ns_q       <= LampGreen;
      ew_q       <= LampRed;
      walk_q     <= 1'b0;
      seg_q      <= SegGreen;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      ped_wait_q <= ped_wait_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
      seg_q      <= seg_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign walk     = walk_q;
  assign ped_wait = ped_wait_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Directed bench: stimulus pushes the expected post-edge state per cycle; a monitor pops and
// compares it after every rising edge, plus the lamp safety rules.
module tb_traffic_light_intersection;

  typedef enum {PG, PY, PA, PE, PF, PW} ph_e;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       pw;
    logic [7:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       walk, ped_wait;
  logic [7:0] seg;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  traffic_light_intersection dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_wait (ped_wait),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(input ph_e ph, input logic pw);
    exp_t e;
    e.ns   = (ph == PG) ? 3'b001 : (ph == PY) ? 3'b010 : 3'b100;
    e.ew   = (ph == PE) ? 3'b001 : (ph == PF) ? 3'b010 : 3'b100;
    e.walk = (ph == PW);
    e.pw   = pw;
    case (ph)
      PG:      e.seg = 8'b01110111;
      PY:      e.seg = 8'b01110110;
      PW:      e.seg = 8'b00111110;
      default: e.seg = 8'b00001110;
    endcase
    return e;
  endfunction

  // Drive one cycle's inputs and queue the state expected after the next rising edge.
  task automatic cyc(input ph_e ph, input logic pw, input logic req = 1'b0,
                     input logic en = 1'b1, input logic rst = 1'b0);
    @(negedge clk);
    reset   = rst;
    enable  = en;
    ped_req = req;
    exp_q.push_back(make_exp(ph, pw));
  endtask

  task automatic run(input ph_e ph, input int n, input logic pw = 1'b0);
    for (int i = 0; i < n; i++) cyc(ph, pw);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ns_light", {5'b0, ns_light}, {5'b0, e.ns});
        check("ew_light", {5'b0, ew_light}, {5'b0, e.ew});
        check("walk", {7'b0, walk}, {7'b0, e.walk});
        check("ped_wait", {7'b0, ped_wait}, {7'b0, e.pw});
        check("seg", seg, e.seg);
        check("ns_onehot", {7'b0, $onehot(ns_light)}, 8'd1);
        check("ew_onehot", {7'b0, $onehot(ew_light)}, 8'd1);
        check("conflict", {7'b0, (ns_light != 3'b100) && (ew_light != 3'b100)}, 8'd0);
      end
    end
  end

  initial begin : stimulus
    // Reset, then the plain cycle: G4 Y2 A1 E4 F2 A1, back to G.
    cyc(PG, 0, 0, 1, 1);
    run(PG, 3); run(PY, 2); run(PA, 1); run(PE, 4); run(PF, 2); run(PA, 1);
    cyc(PG, 0);
    // Pedestrian pulse during EW green leads to a 3-cycle walk.
    run(PG, 3); run(PY, 2); run(PA, 1); cyc(PE, 0);
    cyc(PE, 1, 1); run(PE, 2, 1); run(PF, 2, 1); run(PA, 1, 1);
    run(PW, 3, 0); cyc(PG, 0);
    // Enable low mid-yellow for 5 cycles; a request still latches while frozen.
    run(PG, 3); cyc(PY, 0);
    cyc(PY, 0, 0, 0); cyc(PY, 0, 0, 0); cyc(PY, 1, 1, 0); cyc(PY, 1, 0, 0); cyc(PY, 1, 0, 0);
    cyc(PY, 1); cyc(PA, 1); run(PE, 4, 1); run(PF, 2, 1); cyc(PA, 1);
    run(PW, 2, 0);
    // Reset mid-walk, with a request on the same edge that reset must override.
    cyc(PG, 0, 1, 1, 1);
    // Several requests in one cycle give one walk; a request during walk is ignored.
    cyc(PG, 1, 1); cyc(PG, 1); cyc(PG, 1, 1); cyc(PY, 1); cyc(PY, 1, 1); cyc(PA, 1);
    run(PE, 4, 1); run(PF, 2, 1); cyc(PA, 1);
    cyc(PW, 0); cyc(PW, 0, 1); cyc(PW, 0); cyc(PG, 0);
    run(PG, 3); run(PY, 2); run(PA, 1); run(PE, 4); run(PF, 2); run(PA, 1); cyc(PG, 0);
    // Request arriving on the edge that enters walk is consumed.
    run(PG, 3); cyc(PY, 1, 1); cyc(PY, 1); cyc(PA, 1); run(PE, 4, 1); run(PF, 2, 1);
    cyc(PA, 1); cyc(PW, 0, 1); run(PW, 2, 0); cyc(PG, 0);
    @(negedge clk);
    ped_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
